// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, execute redirect and the decode hand-off.
// The master modport is the fetch stage; the slave modport is its environment (memory, execute, decode).
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            instr_ready;

  logic            misalign_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, misalign_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, misalign_fault,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Non-pipelined instruction fetch: one outstanding imem request, registered hand-off to decode,
// redirect handling with drain of an in-flight response, and a sticky misaligned-target fault.
module instr_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            req_q;
  logic            valid_q;
  logic            fault_q;

  logic            gnt_q;
  logic            misaligned;
  logic            redirect_drain;

  // A grant only counts while a request is actually being driven (e.g. not in the
  // first cycle after reset, where imem_req is still low).
  assign gnt_q      = bus.imem_gnt & req_q;
  assign misaligned = |bus.redirect_pc[1:0];

  // A redirect must drain when a granted request's response is still owed.
  always_comb begin
    redirect_drain = 1'b0;
    case (state)
      S_FETCH: redirect_drain = gnt_q;
      S_WAIT:  redirect_drain = ~bus.imem_rvalid;
      S_DRAIN: redirect_drain = ~bus.imem_rvalid;
      default: redirect_drain = 1'b0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers; blocking here would create ordering-dependent logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (state == S_FAULT) begin
      // Sticky until reset: rvalid and redirect are ignored, outputs stay quiet.
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b1;
    end else if (bus.redirect && misaligned) begin
      state   <= S_FAULT;
      pc_q    <= bus.redirect_pc;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b1;
    end else if (bus.redirect) begin
      // Redirect beats instr_ready in HOLD, so the target replaces pc+4.
      state   <= redirect_drain ? S_DRAIN : S_FETCH;
      pc_q    <= bus.redirect_pc;
      instr_q <= NOP_INSTR;
      req_q   <= ~redirect_drain;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (gnt_q) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            state   <= S_HOLD;
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            state   <= S_FETCH;
            pc_q    <= bus.pc_plus4;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= S_FETCH;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req       = req_q;
  assign bus.imem_addr      = pc_q;
  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_q + XLEN'(4);
  assign bus.instr          = instr_q;
  assign bus.instr_valid    = valid_q;
  assign bus.misalign_fault = fault_q;

endmodule
